// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Round-robin scan sequencer for a 16:1 bit mux built as a two-level 4:1 tree.
// For each enabled channel it drives the mux select, waits a settle time,
// captures the mux output bit and offers {channel, bit} to a downstream
// consumer over a valid/ready handshake.
//
// Build option:
//   MUX_SCAN_FRAME_CNT_EN  when defined, adds output frame_cnt[7:0], a
//                          modulo-256 count of frame_done pulses that survives
//                          stop/start and is cleared only by rst.
//
// Ports:
//   clk           in   1        system clock, rising edge
//   rst           in   1        synchronous reset, active-high
//   start         in   1        begin scanning (looked at in IDLE only)
//   stop          in   1        end scanning after the current sample
//   ch_mask       in   N_CH     channel enable, bit i = channel i
//   dwell         in   DWELL_W  extra settle cycles after a select change
//   mux_sel       out  SEL_W    registered select to the mux
//   mux_out       in   1        mux output bit
//   sample_valid  out  1        sample available
//   sample_ready  in   1        consumer accepts the sample
//   sample_ch     out  SEL_W    channel of the current sample
//   sample_bit    out  1        captured mux_out
//   busy          out  1        high in every state except IDLE
//   frame_done    out  1        1-cycle pulse after the last enabled channel
//                               of a frame is accepted
//   frame_cnt     out  8        frame counter (MUX_SCAN_FRAME_CNT_EN only)
module mux_scan_ctrl #(
  parameter int N_CH    = 16,
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   mux_sel,
  input  logic               mux_out,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic [SEL_W-1:0]   sample_ch,
  output logic               sample_bit,
  output logic               busy,
`ifdef MUX_SCAN_FRAME_CNT_EN
  output logic [7:0]         frame_cnt,
`endif
  output logic               frame_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [N_CH-1:0]    mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               stop_pend;

  // Lowest set bit of a mask (0 when the mask is empty).
  function automatic logic [SEL_W-1:0] lowest_idx(input logic [N_CH-1:0] m);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  // Highest set bit of a mask (0 when the mask is empty).
  function automatic logic [SEL_W-1:0] highest_idx(input logic [N_CH-1:0] m);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (m[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  // Lowest set bit strictly above cur. Only used when cur is not the highest
  // enabled channel, so a higher one always exists and no wrap is needed.
  function automatic logic [SEL_W-1:0] next_above(input logic [N_CH-1:0]  m,
                                                   input logic [SEL_W-1:0] cur);
    logic [SEL_W-1:0] idx;
    idx = cur;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  logic stop_eff;
  logic handshake;
  logic last_ch;

  // A stop seen earlier in the frame counts just like one arriving now.
  assign stop_eff  = stop | stop_pend;
  assign handshake = sample_valid & sample_ready;
  assign last_ch   = (mux_sel == highest_idx(mask_q));

  // cnt, mask_q and dwell_q are always loaded before they are used, so they
  // carry no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mux_sel      <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_bit   <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      stop_pend    <= 1'b0;
`ifdef MUX_SCAN_FRAME_CNT_EN
      frame_cnt    <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          stop_pend    <= 1'b0;
          sample_valid <= 1'b0;
          busy         <= 1'b0;
          // stop in the same cycle as start keeps the block idle.
          if (start && !stop && (ch_mask != '0)) begin
            mask_q  <= ch_mask;
            dwell_q <= dwell;
            mux_sel <= lowest_idx(ch_mask);
            cnt     <= dwell;
            busy    <= 1'b1;
            state   <= SETTLE;
          end
        end

        SETTLE: begin
          if (stop_eff) begin
            // Abandon the settle; nothing is emitted for this channel.
            stop_pend <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else begin
            sample_bit   <= mux_out;
            sample_ch    <= mux_sel;
            sample_valid <= 1'b1;
            state        <= HOLD;
          end
        end

        HOLD: begin
          if (handshake) begin
            sample_valid <= 1'b0;
            if (last_ch) begin
              // Frame boundary: configuration is only sampled here, so
              // mid-frame changes to mask/dwell take effect next frame.
              frame_done <= 1'b1;
`ifdef MUX_SCAN_FRAME_CNT_EN
              frame_cnt  <= frame_cnt + 8'd1;
`endif
              mask_q     <= ch_mask;
              dwell_q    <= dwell;
            end
            if (stop_eff) begin
              // mux_sel is left on the channel just accepted.
              stop_pend <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else if (last_ch) begin
              if (ch_mask == '0) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                mux_sel <= lowest_idx(ch_mask);
                cnt     <= dwell;
                state   <= SETTLE;
              end
            end else begin
              mux_sel <= next_above(mask_q, mux_sel);
              cnt     <= dwell_q;
              state   <= SETTLE;
            end
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed testbench for mux_scan_ctrl. Inputs change 1 time unit after the
// rising edge, outputs are checked at the same point.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] ch_mask;
  logic [7:0]  dwell;
  logic [3:0]  mux_sel;
  logic        mux_out;
  logic        sample_valid;
  logic        sample_ready;
  logic [3:0]  sample_ch;
  logic        sample_bit;
  logic        busy;
  logic        frame_done;
`ifdef MUX_SCAN_FRAME_CNT_EN
  logic [7:0]  frame_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mux_scan_ctrl #(.N_CH(16), .SEL_W(4), .DWELL_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .ch_mask      (ch_mask),
    .dwell        (dwell),
    .mux_sel      (mux_sel),
    .mux_out      (mux_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_ch    (sample_ch),
    .sample_bit   (sample_bit),
    .busy         (busy),
`ifdef MUX_SCAN_FRAME_CNT_EN
    .frame_cnt    (frame_cnt),
`endif
    .frame_done   (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  initial begin
    // Reset held 2 cycles with start high
    rst = 1'b1; start = 1'b1; stop = 1'b0; ch_mask = 16'h0001; dwell = 8'd0;
    mux_out = 1'b1; sample_ready = 1'b1;
    ticks(2);
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ch", sample_ch, 0);
    chk("rst_bit", sample_bit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
`ifdef MUX_SCAN_FRAME_CNT_EN
    chk("rst_frame_cnt", frame_cnt, 0);
`endif
    rst = 1'b0; start = 1'b0;
    tick();
    chk("after_rst_busy", busy, 0);

    // Single channel, dwell 0: sample every 2 cycles, frame_done each sample
    ch_mask = 16'h0001; dwell = 8'd0; mux_out = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_busy", busy, 1);
    chk("t2_valid_settle", sample_valid, 0);
    tick();
    chk("t2_valid1", sample_valid, 1);
    chk("t2_ch1", sample_ch, 0);
    chk("t2_bit1", sample_bit, 1);
    chk("t2_fd_early", frame_done, 0);
    tick();
    chk("t2_valid_drop", sample_valid, 0);
    chk("t2_fd1", frame_done, 1);
    tick();
    chk("t2_valid2", sample_valid, 1);
    chk("t2_fd_clear", frame_done, 0);
    tick();
    chk("t2_fd2", frame_done, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t2_stop_busy", busy, 0);
    chk("t2_stop_valid", sample_valid, 0);

    // Mask 8005, dwell 3: channels 0,2,15,0 at 5 cycles per sample
    ch_mask = 16'h8005; dwell = 8'd3; mux_out = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_sel0", mux_sel, 0);
    ticks(3);
    chk("t3_not_yet", sample_valid, 0);
    tick();
    chk("t3_valid_a", sample_valid, 1);
    chk("t3_ch_a", sample_ch, 0);
    chk("t3_bit_a", sample_bit, 0);
    tick();
    chk("t3_sel2", mux_sel, 2);
    chk("t3_valid_drop", sample_valid, 0);
    ticks(4);
    chk("t3_ch_b", sample_ch, 2);
    chk("t3_valid_b", sample_valid, 1);
    tick();
    chk("t3_sel15", mux_sel, 15);
    chk("t3_no_fd", frame_done, 0);
    ticks(4);
    chk("t3_ch_c", sample_ch, 15);
    tick();
    chk("t3_fd", frame_done, 1);
    chk("t3_wrap_sel", mux_sel, 0);
    ticks(4);
    chk("t3_ch_d", sample_ch, 0);
    chk("t3_valid_d", sample_valid, 1);
    // stop while holding ch 0 with ready high: accept then idle
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_stop_busy", busy, 0);
    chk("t3_stop_valid", sample_valid, 0);
    chk("t3_stop_fd", frame_done, 0);

    // Mask 0012, ready low in HOLD: outputs stay put
    ch_mask = 16'h0012; dwell = 8'd0; mux_out = 1'b1; sample_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_sel1", mux_sel, 1);
    tick();
    mux_out = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", sample_valid, 1);
      chk("t4_hold_ch", sample_ch, 1);
      chk("t4_hold_bit", sample_bit, 1);
      tick();
    end
    sample_ready = 1'b1;
    tick();
    chk("t4_next_sel", mux_sel, 4);
    chk("t4_valid_drop", sample_valid, 0);
    tick();
    chk("t4_ch4", sample_ch, 4);
    chk("t4_bit4", sample_bit, 0);
    tick();
    chk("t4_fd", frame_done, 1);
    chk("t4_wrap_sel", mux_sel, 1);
    mux_out = 1'b1;
    tick();
    chk("t4_ch1_again", sample_ch, 1);
    // stop during HOLD on ch 1: accepted, then IDLE, no ch 4 sample
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_stop_busy", busy, 0);
    chk("t4_stop_valid", sample_valid, 0);
    ticks(3);
    chk("t4_no_ch4_valid", sample_valid, 0);
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_sel_kept", mux_sel, 1);

    // stop during SETTLE: IDLE next cycle, no sample
    ch_mask = 16'h0012; dwell = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_busy", busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5_stop_busy", busy, 0);
    chk("t5_stop_valid", sample_valid, 0);
    ticks(8);
    chk("t5_no_valid", sample_valid, 0);

    // start with mask 0 ignored; start+stop together ignored
    ch_mask = 16'h0000; dwell = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_mask0_busy", busy, 0);
    ch_mask = 16'h0001; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("t6_startstop_busy", busy, 0);
    tick();
    chk("t6_startstop_valid", sample_valid, 0);

    // Mask cleared mid-frame: frame completes, then IDLE
    ch_mask = 16'h0012; dwell = 8'd0; sample_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; ch_mask = 16'h0000;
    tick();
    chk("t7_ch1", sample_ch, 1);
    tick();
    chk("t7_sel4", mux_sel, 4);
    chk("t7_busy_mid", busy, 1);
    tick();
    chk("t7_ch4", sample_ch, 4);
    tick();
    chk("t7_fd", frame_done, 1);
    chk("t7_idle_busy", busy, 0);
    chk("t7_idle_valid", sample_valid, 0);
`ifdef MUX_SCAN_FRAME_CNT_EN
    chk("t7_frame_cnt5", frame_cnt, 5);
`endif

    // Reset mid-operation drops the outstanding sample
    ch_mask = 16'h0001; dwell = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t8_valid_pre", sample_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t8_rst_valid", sample_valid, 0);
    chk("t8_rst_fd", frame_done, 0);
    chk("t8_rst_busy", busy, 0);
    chk("t8_rst_ch", sample_ch, 0);
    chk("t8_rst_bit", sample_bit, 0);
`ifdef MUX_SCAN_FRAME_CNT_EN
    chk("t8_rst_frame_cnt", frame_cnt, 0);
`endif

    // Three single-channel frames
    ch_mask = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    ticks(6);
    chk("t9_fd3", frame_done, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t9_idle", busy, 0);
`ifdef MUX_SCAN_FRAME_CNT_EN
    chk("t9_frame_cnt3", frame_cnt, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
